// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module adder_ks (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_c,
  output logic [31:0] o_sum,
  output logic        o_carry
);
  logic [31:0] gk, pk;
  // Kogge-Stone prefix tree with the carry-in folded into bit 0's generate
  always_comb begin
    gk = {i_a[31:1] & i_b[31:1], (i_a[0] & i_b[0]) | ((i_a[0] ^ i_b[0]) & i_c)};
    pk = i_a ^ i_b;
    for (int l = 1; l < 32; l = l * 2) begin
      gk = gk | (pk & (gk << l));
      pk = pk & (pk << l);
    end
  end
  assign o_sum   = (i_a ^ i_b) ^ {gk[30:0], i_c};
  assign o_carry = gk[31];
endmodule

module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_busy
);
  if (WIDTH != 32) begin : g_width
    $error("div_iter: WIDTH must be 32");
  end
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] quo, rem, dvs, sh, x, abs_a, abs_b, add_a, add_b, sum;
  logic [$clog2(WIDTH)-1:0] cnt;
  logic [1:0] op;
  logic neg_q, neg_r, s_a, s_b, dz, ovf, special, accept, carry, ok, neg;
  assign s_a     = ~i_op[0] & i_dividend[WIDTH-1];
  assign s_b     = ~i_op[0] & i_divisor[WIDTH-1];
  assign abs_a   = s_a ? -i_dividend : i_dividend;
  assign abs_b   = s_b ? -i_divisor : i_divisor;
  assign dz      = i_divisor == '0;
  assign ovf     = ~i_op[0] & (i_dividend == {1'b1, {(WIDTH-1){1'b0}}}) & (&i_divisor);
  assign special = dz | ovf;
  assign accept  = i_valid & o_ready & ~i_flush;
  assign sh      = {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign x       = op[1] ? rem : quo;
  assign neg     = ~op[0] & (op[1] ? neg_r : neg_q);
  assign add_a   = state == FIX ? '0 : sh;
  assign add_b   = ~(state == FIX ? x : dvs);
  assign ok      = rem[WIDTH-1] | carry;
  assign o_ready = state == IDLE;
  assign o_valid = state == DONE;
  assign o_busy  = state != IDLE;
  adder_ks u_add (
    .i_a    (add_a),
    .i_b    (add_b),
    .i_c    (1'b1),
    .o_sum  (sum),
    .o_carry(carry)
  );
  // next-state: flush always returns to IDLE, special cases skip straight to DONE
  always_comb begin
    state_nxt = i_flush ? IDLE
              : state == IDLE ? (accept ? (special ? DONE : CALC) : IDLE)
              : state == CALC ? (cnt == '0 ? FIX : CALC)
              : state == FIX  ? DONE
              : (i_ready ? IDLE : DONE);
  end
  // state register
  always_ff @(posedge i_clk) begin
    state <= i_reset ? IDLE : state_nxt;
  end
  // operand latch, shift-subtract iteration and sign fix-up into o_result
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      op       <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      o_result <= '0;
    end else begin
      if (accept) begin
        op    <= i_op;
        quo   <= abs_a;
        rem   <= '0;
        dvs   <= abs_b;
        cnt   <= $bits(cnt)'(WIDTH - 1);
        neg_q <= s_a ^ s_b;
        neg_r <= s_a;
        if (special)
          o_result <= dz ? (i_op[1] ? i_dividend : '1)
                         : (i_op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}});
      end
      if (state == CALC) begin
        rem <= ok ? sum : sh;
        quo <= {quo[WIDTH-2:0], ok};
        cnt <= cnt - 1'b1;
      end
      if (state == FIX)
        o_result <= neg ? sum : x;
    end
  end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed checks of div_iter results, latency, backpressure, flush and reset
module tb_div_iter;
  logic clk = 0, rst = 1, flush = 0, valid = 0, ready = 0, o_ready, o_valid, o_busy;
  logic [1:0] op = 0;
  logic [31:0] dividend = 0, divisor = 0, result;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  div_iter dut (
    .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_valid(valid), .o_ready(o_ready),
    .i_op(op), .i_dividend(dividend), .i_divisor(divisor), .o_valid(o_valid),
    .i_ready(ready), .o_result(result), .o_busy(o_busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    chk("ready_before_accept", {31'b0, o_ready}, 1);
    valid = 1; op = o; dividend = a; divisor = b;
    @(posedge clk);
    #1 valid = 0; op = ~o; dividend = 32'hDEAD_BEEF; divisor = 32'h0000_0003;
  endtask
  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int lat, input int hold);
    int n;
    start(o, a, b);
    n = 0;
    do begin @(negedge clk); n++; end while (!o_valid && n < 100);
    chk({tag, "_latency"}, n, lat);
    chk(tag, result, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_held_valid"}, {31'b0, o_valid}, 1);
      chk({tag, "_held_result"}, result, exp);
      chk({tag, "_held_ready"}, {31'b0, o_ready}, 0);
    end
    ready = 1;
    @(posedge clk);
    #1 ready = 0;
    @(negedge clk);
    chk({tag, "_valid_dropped"}, {31'b0, o_valid}, 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ready", {31'b0, o_ready}, 1);
    chk("rst_valid", {31'b0, o_valid}, 0);
    chk("rst_busy", {31'b0, o_busy}, 0);
    chk("rst_result", result, 0);
    run("divu_100_7", 2'b01, 100, 7, 14, 34, 0);
    run("remu_100_7", 2'b11, 100, 7, 2, 34, 0);
    run("divu_max_1", 2'b01, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 34, 0);
    run("div_m7_2", 2'b00, -32'sd7, 2, 32'hFFFF_FFFD, 34, 0);
    run("rem_m7_2", 2'b10, -32'sd7, 2, 32'hFFFF_FFFF, 34, 0);
    run("rem_7_m2", 2'b10, 7, -32'sd2, 1, 34, 0);
    run("div_m8_m2", 2'b00, -32'sd8, -32'sd2, 4, 34, 0);
    run("div_5_0", 2'b00, 5, 0, 32'hFFFF_FFFF, 1, 0);
    run("remu_1234_0", 2'b11, 32'h1234, 0, 32'h1234, 1, 0);
    run("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 0);
    run("divu_bp", 2'b01, 1000, 10, 100, 34, 10);
    run("remu_after_bp", 2'b11, 1000, 7, 6, 34, 0);
    @(negedge clk);
    valid = 1; flush = 1; op = 2'b01; dividend = 9; divisor = 3;
    @(posedge clk);
    #1 valid = 0; flush = 0;
    @(negedge clk);
    chk("flush_idle_blocks_accept", {31'b0, o_busy}, 0);
    start(2'b01, 50, 5);
    repeat (15) @(negedge clk);
    flush = 1;
    @(posedge clk);
    #1 flush = 0;
    @(negedge clk);
    chk("flush_ready", {31'b0, o_ready}, 1);
    chk("flush_valid", {31'b0, o_valid}, 0);
    chk("flush_busy", {31'b0, o_busy}, 0);
    run("divu_9_3_after_flush", 2'b01, 9, 3, 3, 34, 0);
    start(2'b01, 50, 5);
    repeat (20) @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_mid_ready", {31'b0, o_ready}, 1);
    chk("reset_mid_valid", {31'b0, o_valid}, 0);
    chk("reset_mid_result", result, 0);
    run("divu_9_3_after_reset", 2'b01, 9, 3, 3, 34, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
